// File: rtl/mem_byte_stage.sv
// Memory-access stage: byte-serial loads/stores over a synchronous byte RAM,
// stalling the pipeline while busy; non-memory results pass through in one cycle.
module mem_byte_stage #(
    parameter int RAM_ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [4:0]            wd_i,
    input  logic                  wreg_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            mem_op_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [31:0]           mem_sdata_i,
    input  logic [7:0]            ram_din_i,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [7:0]            ram_dout_o,
    output logic                  stall_req_o,
    output logic                  valid_o,
    output logic [4:0]            wd_o,
    output logic                  wreg_o,
    output logic [31:0]           wdata_o
);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [3:0] {
        OP_NOP = 4'd0, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
    } mem_op_t;

    state_t                state;
    logic [2:0]            cnt;
    mem_op_t               op_q;
    logic [RAM_ADDR_W-1:0] addr_q;
    logic [31:0]           sdata_q;
    logic [4:0]            wd_q;
    logic                  wreg_q;
    logic [23:0]           asm_q;

    mem_op_t               op_in;
    logic [2:0]            n_in;
    logic [2:0]            n_q;
    logic                  store_q;
    logic [31:0]           ld_word;
    logic [31:0]           ld_result;
    logic                  unused_addr_hi;

    function automatic logic [2:0] op_bytes(input mem_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            OP_LW, OP_SW:         return 3'd4;
            default:              return 3'd0;
        endcase
    endfunction

    assign op_in          = mem_op_t'(mem_op_i);
    assign n_in           = op_bytes(op_in);
    assign n_q            = op_bytes(op_q);
    assign store_q        = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
    assign stall_req_o    = (state == BUSY);
    assign unused_addr_hi = ^mem_addr_i[31:RAM_ADDR_W];

    // RAM port decodes from registered state only; loads idle the port at cnt = N
    always_comb begin
        ram_addr_o = '0;
        ram_we_o   = 1'b0;
        ram_dout_o = '0;
        if (state == BUSY && cnt < n_q) begin
            ram_addr_o = addr_q + RAM_ADDR_W'(cnt);
            ram_we_o   = store_q;
            if (store_q)
                ram_dout_o = 8'(sdata_q >> {cnt, 3'b000});
        end
    end

    // Read data lags the address by one cycle, so byte cnt-1 arrives at cnt
    always_comb begin
        ld_word = {8'h00, asm_q};
        case (cnt)
            3'd1:    ld_word[7:0]   = ram_din_i;
            3'd2:    ld_word[15:8]  = ram_din_i;
            3'd3:    ld_word[23:16] = ram_din_i;
            3'd4:    ld_word[31:24] = ram_din_i;
            default: ;
        endcase
        ld_result = ld_word;
        case (op_q)
            OP_LB:   ld_result = {{24{ld_word[7]}}, ld_word[7:0]};
            OP_LH:   ld_result = {{16{ld_word[15]}}, ld_word[15:0]};
            OP_LBU:  ld_result = {24'h000000, ld_word[7:0]};
            OP_LHU:  ld_result = {16'h0000, ld_word[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= OP_NOP;
            addr_q  <= '0;
            sdata_q <= '0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            asm_q   <= '0;
            valid_o <= 1'b0;
            wd_o    <= '0;
            wreg_o  <= 1'b0;
            wdata_o <= '0;
        end else begin
            valid_o <= 1'b0;
            wreg_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (n_in != 3'd0) begin
                            state   <= BUSY;
                            cnt     <= '0;
                            op_q    <= op_in;
                            addr_q  <= mem_addr_i[RAM_ADDR_W-1:0];
                            sdata_q <= mem_sdata_i;
                            wd_q    <= wd_i;
                            wreg_q  <= wreg_i;
                        end else begin
                            valid_o <= 1'b1;
                            wd_o    <= wd_i;
                            wreg_o  <= wreg_i;
                            wdata_o <= wdata_i;
                        end
                    end
                end
                BUSY: begin
                    if (store_q) begin
                        if (cnt == n_q - 3'd1) begin
                            state   <= IDLE;
                            valid_o <= 1'b1;
                            wd_o    <= wd_q;
                            wdata_o <= '0;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end else begin
                        if (cnt != 3'd0)
                            asm_q <= ld_word[23:0];
                        if (cnt == n_q) begin
                            state   <= IDLE;
                            valid_o <= 1'b1;
                            wd_o    <= wd_q;
                            wreg_o  <= wreg_q;
                            wdata_o <= ld_result;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_stage.sv
// Bench for mem_byte_stage: directed scenarios plus randomized ops checked
// against a byte-array memory model with arithmetic load extension.
module tb_mem_byte_stage;

    localparam int AW       = 17;
    localparam int RAM_SIZE = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_i = 1'b0;
    logic [4:0]    wd_i = '0;
    logic          wreg_i = 1'b0;
    logic [31:0]   wdata_i = '0;
    logic [3:0]    mem_op_i = '0;
    logic [31:0]   mem_addr_i = '0;
    logic [31:0]   mem_sdata_i = '0;
    logic [7:0]    ram_din_i;
    logic [AW-1:0] ram_addr_o;
    logic          ram_we_o;
    logic [7:0]    ram_dout_o;
    logic          stall_req_o;
    logic          valid_o;
    logic [4:0]    wd_o;
    logic          wreg_o;
    logic [31:0]   wdata_o;

    logic [7:0]    ram     [RAM_SIZE];
    logic [7:0]    ref_mem [RAM_SIZE];
    logic          sync_req = 1'b0;
    logic [AW-1:0] addr_trace[$];
    logic          we_trace[$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_byte_stage #(.RAM_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
        .mem_sdata_i(mem_sdata_i), .ram_din_i(ram_din_i), .ram_addr_o(ram_addr_o),
        .ram_we_o(ram_we_o), .ram_dout_o(ram_dout_o), .stall_req_o(stall_req_o),
        .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o)
    );

    // Synchronous byte RAM; sync_req copies the reference image in one cycle
    always @(posedge clk) begin
        if (sync_req) begin
            for (int i = 0; i < RAM_SIZE; i++) ram[i] <= ref_mem[i];
        end else if (ram_we_o) begin
            ram[ram_addr_o] <= ram_dout_o;
        end
        ram_din_i <= ram[ram_addr_o];
    end

    function automatic int nbytes(input int op);
        case (op)
            1, 4, 6: return 1;
            2, 5, 7: return 2;
            3, 8:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input int op, input logic [31:0] addr);
        longint v = 0;
        int n = nbytes(op);
        for (int k = 0; k < n; k++)
            v += longint'(ref_mem[int'((addr + 32'(k)) % RAM_SIZE)]) << (8 * k);
        if ((op == 1 || op == 2) && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return 32'(v);
    endfunction

    task automatic load_ram();
        @(negedge clk); sync_req = 1'b1;
        @(posedge clk); #1; sync_req = 1'b0;
    endtask

    // Presents one instruction and counts edges after the accepting edge until valid_o
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         output int edges, output int stalls, output logic [4:0] o_wd,
                         output logic o_wreg, output logic [31:0] o_wdata, output logic timeout);
        @(negedge clk);
        valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sdata;
        wd_i = wd; wreg_i = wreg; wdata_i = wdata;
        @(posedge clk); #1;
        valid_i = 1'b0;
        edges = 0; stalls = 0; timeout = 1'b1;
        o_wd = 'x; o_wreg = 1'bx; o_wdata = 'x;
        addr_trace.delete(); we_trace.delete();
        for (int i = 0; i < 16; i++) begin
            if (valid_o) begin
                timeout = 1'b0; o_wd = wd_o; o_wreg = wreg_o; o_wdata = wdata_o;
                break;
            end
            if (stall_req_o) stalls++;
            addr_trace.push_back(ram_addr_o);
            we_trace.push_back(ram_we_o);
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        valid_i = 1'b1; mem_op_i = 4'd0; wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h12345678;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({valid_o, wd_o, wreg_o, wdata_o, ram_we_o, ram_addr_o, ram_dout_o, stall_req_o} !== 66'd0) begin
            fails++;
            $display("FAIL reset_state: got v=%b wd=%h wreg=%b wdata=%h we=%b addr=%h dout=%h stall=%b required all 0",
                     valid_o, wd_o, wreg_o, wdata_o, ram_we_o, ram_addr_o, ram_dout_o, stall_req_o);
        end
        valid_i = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_nonmem();
        int e, s; logic [4:0] w; logic wr; logic [31:0] d; logic to;
        issue(4'd0, 32'h0, 32'h0, 5'd3, 1'b1, 32'hDEADBEEF, e, s, w, wr, d, to);
        tests++; if ({to, e, s} !== {1'b0, 32'd0, 32'd0}) begin fails++;
            $display("FAIL nonmem_latency: got to=%b edges=%0d stalls=%0d required 0/0/0", to, e, s); end
        tests++; if ({w, wr, d} !== {5'd3, 1'b1, 32'hDEADBEEF}) begin fails++;
            $display("FAIL nonmem_result: got wd=%0d wreg=%b wdata=%h required 3 1 deadbeef", w, wr, d); end
        @(posedge clk); #1;
        tests++; if ({valid_o, wreg_o} !== 2'b00) begin fails++;
            $display("FAIL nonmem_pulse: got valid=%b wreg=%b required 0 0", valid_o, wreg_o); end
        issue(4'd12, 32'h55, 32'h0, 5'd7, 1'b0, 32'h0BADF00D, e, s, w, wr, d, to);
        tests++; if ({to, e, w, wr, d} !== {1'b0, 32'd0, 5'd7, 1'b0, 32'h0BADF00D}) begin fails++;
            $display("FAIL op12_as_nop: got to=%b edges=%0d wd=%0d wreg=%b wdata=%h required 0 0 7 0 0badf00d",
                     to, e, w, wr, d); end
    endtask

    task automatic test_lw();
        int e, s; logic [4:0] w; logic wr; logic [31:0] d; logic to;
        ref_mem[32'h100] = 8'h11; ref_mem[32'h101] = 8'h22;
        ref_mem[32'h102] = 8'h33; ref_mem[32'h103] = 8'h44;
        load_ram();
        issue(4'd3, 32'h100, 32'h0, 5'd9, 1'b1, 32'h0, e, s, w, wr, d, to);
        tests++; if ({to, e, s} !== {1'b0, 32'd5, 32'd5}) begin fails++;
            $display("FAIL lw_latency: got to=%b edges=%0d stalls=%0d required 0/5/5", to, e, s); end
        tests++; if ({w, wr, d} !== {5'd9, 1'b1, 32'h44332211}) begin fails++;
            $display("FAIL lw_result: got wd=%0d wreg=%b wdata=%h required 9 1 44332211", w, wr, d); end
        for (int k = 0; k < 4; k++) begin
            tests++; if ({addr_trace[k], we_trace[k]} !== {AW'(32'h100 + k), 1'b0}) begin fails++;
                $display("FAIL lw_addr%0d: got addr=%h we=%b required %h 0", k, addr_trace[k], we_trace[k], 32'h100 + k); end
        end
    endtask

    task automatic test_lb_lbu_lh_wrap();
        int e, s; logic [4:0] w; logic wr; logic [31:0] d; logic to;
        ref_mem[32'h20] = 8'h80; ref_mem[32'h1FFFF] = 8'h34; ref_mem[0] = 8'hF2;
        load_ram();
        issue(4'd1, 32'h20, 32'h0, 5'd1, 1'b1, 32'h0, e, s, w, wr, d, to);
        tests++; if ({to, e, d} !== {1'b0, 32'd2, 32'hFFFFFF80}) begin fails++;
            $display("FAIL lb_sign: got to=%b edges=%0d wdata=%h required 0 2 ffffff80", to, e, d); end
        issue(4'd4, 32'h20, 32'h0, 5'd2, 1'b1, 32'h0, e, s, w, wr, d, to);
        tests++; if ({to, e, d} !== {1'b0, 32'd2, 32'h00000080}) begin fails++;
            $display("FAIL lbu_zero: got to=%b edges=%0d wdata=%h required 0 2 00000080", to, e, d); end
        issue(4'd2, 32'hFFFFFFFF, 32'h0, 5'd4, 1'b1, 32'h0, e, s, w, wr, d, to);
        tests++; if ({to, e, s, d} !== {1'b0, 32'd3, 32'd3, 32'hFFFFF234}) begin fails++;
            $display("FAIL lh_wrap: got to=%b edges=%0d stalls=%0d wdata=%h required 0 3 3 fffff234", to, e, s, d); end
        tests++; if ({addr_trace[0], addr_trace[1]} !== {17'h1FFFF, 17'h00000}) begin fails++;
            $display("FAIL lh_wrap_addr: got %h %h required 1ffff 00000", addr_trace[0], addr_trace[1]); end
    endtask

    task automatic test_sw();
        int e, s, wc; logic [4:0] w; logic wr; logic [31:0] d; logic to;
        for (int k = 0; k < 5; k++) ref_mem[32'h40 + k] = 8'h00;
        load_ram();
        issue(4'd8, 32'h40, 32'hA1B2C3D4, 5'd5, 1'b1, 32'h0, e, s, w, wr, d, to);
        wc = 0;
        foreach (we_trace[i]) wc += int'(we_trace[i]);
        tests++; if ({to, e, s, wc, wr} !== {1'b0, 32'd4, 32'd4, 32'd4, 1'b0}) begin fails++;
            $display("FAIL sw_timing: got to=%b edges=%0d stalls=%0d we_cycles=%0d wreg=%b required 0 4 4 4 0",
                     to, e, s, wc, wr); end
        tests++; if ({ram[32'h40], ram[32'h41], ram[32'h42], ram[32'h43], ram[32'h44]} !== 40'hD4C3B2A100) begin fails++;
            $display("FAIL sw_bytes: got %h %h %h %h %h required d4 c3 b2 a1 00",
                     ram[32'h40], ram[32'h41], ram[32'h42], ram[32'h43], ram[32'h44]); end
    endtask

    task automatic test_sh();
        int e, s, wc; logic [4:0] w; logic wr; logic [31:0] d; logic to;
        ref_mem[32'h10] = 8'h00; ref_mem[32'h11] = 8'h00; ref_mem[32'h12] = 8'h5A;
        load_ram();
        issue(4'd7, 32'h10, 32'h1234BEEF, 5'd6, 1'b1, 32'h0, e, s, w, wr, d, to);
        wc = 0;
        foreach (we_trace[i]) wc += int'(we_trace[i]);
        tests++; if ({to, e, s, wc, wr} !== {1'b0, 32'd2, 32'd2, 32'd2, 1'b0}) begin fails++;
            $display("FAIL sh_timing: got to=%b edges=%0d stalls=%0d we_cycles=%0d wreg=%b required 0 2 2 2 0",
                     to, e, s, wc, wr); end
        tests++; if ({ram[32'h10], ram[32'h11], ram[32'h12]} !== 24'hEFBE5A) begin fails++;
            $display("FAIL sh_bytes: got %h %h %h required ef be 5a", ram[32'h10], ram[32'h11], ram[32'h12]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            valid_i = 1'b1; mem_op_i = 4'd0; wd_i = 5'(k + 1); wreg_i = 1'b1;
            wdata_i = $urandom; exp_d = wdata_i;
            @(posedge clk); #1;
            tests++; if ({valid_o, wd_o, wdata_o, stall_req_o} !== {1'b1, 5'(k + 1), exp_d, 1'b0}) begin fails++;
                $display("FAIL b2b_%0d: got v=%b wd=%0d wdata=%h stall=%b required 1 %0d %h 0",
                         k, valid_o, wd_o, wdata_o, stall_req_o, k + 1, exp_d); end
        end
        // Store, then a non-mem op held from the first busy cycle onward
        @(negedge clk);
        mem_op_i = 4'd6; mem_addr_i = 32'h30; mem_sdata_i = 32'h77; wd_i = 5'd2; wreg_i = 1'b1;
        @(posedge clk); #1;
        mem_op_i = 4'd0; wd_i = 5'd11; wreg_i = 1'b1; wdata_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        tests++; if ({valid_o, wreg_o, stall_req_o} !== 3'b100) begin fails++;
            $display("FAIL b2b_store_done: got v=%b wreg=%b stall=%b required 1 0 0", valid_o, wreg_o, stall_req_o); end
        @(posedge clk); #1;
        valid_i = 1'b0;
        tests++; if ({valid_o, wd_o, wreg_o, wdata_o} !== {1'b1, 5'd11, 1'b1, 32'hCAFEF00D}) begin fails++;
            $display("FAIL b2b_after_store: got v=%b wd=%0d wreg=%b wdata=%h required 1 11 1 cafef00d",
                     valid_o, wd_o, wreg_o, wdata_o); end
        @(posedge clk); #1;
        tests++; if (valid_o !== 1'b0) begin fails++;
            $display("FAIL b2b_idle: got v=%b required 0", valid_o); end
    endtask

    task automatic test_random();
        int e, s, n, op, exp_e; logic [4:0] w; logic wr; logic [31:0] d; logic to;
        logic [31:0] addr, sdata, wdata, exp_d; logic [4:0] wd; logic wreg, is_st;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 15);
            addr = $urandom;
            if ($urandom_range(0, 3) == 0) addr[16:0] = 17'h1FFFD + 17'($urandom_range(0, 2));
            sdata = $urandom; wdata = $urandom; wd = 5'($urandom); wreg = 1'($urandom);
            n = nbytes(op);
            is_st = (op >= 6 && op <= 8);
            exp_e = (n == 0) ? 0 : (is_st ? n : n + 1);
            exp_d = (n == 0) ? wdata : exp_load(op, addr);
            issue(4'(op), addr, sdata, wd, wreg, wdata, e, s, w, wr, d, to);
            tests++; if ({to, e, s} !== {1'b0, 32'(exp_e), 32'(exp_e)}) begin fails++;
                $display("FAIL rnd%0d_timing op=%0d: got to=%b edges=%0d stalls=%0d required 0 %0d %0d",
                         it, op, to, e, s, exp_e, exp_e); end
            if (is_st) begin
                tests++; if (wr !== 1'b0) begin fails++;
                    $display("FAIL rnd%0d_store_wreg: got %b required 0", it, wr); end
                for (int k = 0; k < n; k++) begin
                    ref_mem[int'((addr + 32'(k)) % RAM_SIZE)] = 8'(sdata >> (8 * k));
                    tests++;
                    if (ram[int'((addr + 32'(k)) % RAM_SIZE)] !== ref_mem[int'((addr + 32'(k)) % RAM_SIZE)]) begin
                        fails++;
                        $display("FAIL rnd%0d_store_byte%0d: got %h required %h", it, k,
                                 ram[int'((addr + 32'(k)) % RAM_SIZE)], ref_mem[int'((addr + 32'(k)) % RAM_SIZE)]);
                    end
                end
            end else begin
                tests++; if ({w, wr, d} !== {wd, wreg, exp_d}) begin fails++;
                    $display("FAIL rnd%0d_result op=%0d: got wd=%0d wreg=%b wdata=%h required %0d %b %h",
                             it, op, w, wr, d, wd, wreg, exp_d); end
            end
        end
    endtask

    task automatic test_reset_mid_store();
        int e, s; logic [4:0] w; logic wr; logic [31:0] d; logic to;
        for (int k = 0; k < 4; k++) ref_mem[32'h40 + k] = 8'h00;
        load_ram();
        @(negedge clk);
        valid_i = 1'b1; mem_op_i = 4'd8; mem_addr_i = 32'h40; mem_sdata_i = 32'hA1B2C3D4;
        wd_i = 5'd5; wreg_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        tests++; if ({ram_we_o, stall_req_o, valid_o, ram_addr_o, ram_dout_o} !== 28'd0) begin fails++;
            $display("FAIL midreset_outputs: got we=%b stall=%b v=%b addr=%h dout=%h required all 0",
                     ram_we_o, stall_req_o, valid_o, ram_addr_o, ram_dout_o); end
        @(posedge clk); #1;
        tests++; if ({ram[32'h40], ram[32'h41], valid_o} !== {8'hD4, 8'h00, 1'b0}) begin fails++;
            $display("FAIL midreset_partial: got %h %h v=%b required d4 00 0", ram[32'h40], ram[32'h41], valid_o); end
        @(negedge clk); rst = 1'b1;
        issue(4'd0, 32'h0, 32'h0, 5'd17, 1'b1, 32'h600DCAFE, e, s, w, wr, d, to);
        tests++; if ({to, e, s, w, wr, d} !== {1'b0, 32'd0, 32'd0, 5'd17, 1'b1, 32'h600DCAFE}) begin fails++;
            $display("FAIL midreset_recover: got to=%b edges=%0d stalls=%0d wd=%0d wreg=%b wdata=%h required 0 0 0 17 1 600dcafe",
                     to, e, s, w, wr, d); end
    endtask

    initial begin
        for (int i = 0; i < RAM_SIZE; i++) ref_mem[i] = 8'($urandom);
        load_ram();
        test_reset();
        test_nonmem();
        test_lw();
        test_lb_lbu_lh_wrap();
        test_sw();
        test_sh();
        test_back_to_back();
        test_random();
        test_reset_mid_store();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
